// File: rtl/jk_counter_pkg.sv
// Shared types and helpers for the JK-cell based modulo counter.
// Optional feature macro used by the counter: JK_COUNTER_SATURATE_EN.
package jk_counter_pkg;

  // JK input pair encoded as {J, K}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_t;

  // Map a desired bit transition onto JK inputs. Only hold/set/reset are
  // produced, so a bit that should stay put is never toggled.
  function automatic jk_op_t jk_encode(input logic cur, input logic nxt);
    jk_op_t op;
    op = JK_HOLD;
    if (nxt && !cur) begin
      op = JK_SET;
    end else if (!nxt && cur) begin
      op = JK_RESET;
    end
    return op;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit, falling-edge clocked with synchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic q_q;
  logic q_d;

  // Classic JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle
  always_comb begin
    q_d = q_q;
    case ({J, K})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  // State register; reset only takes effect on a falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// WIDTH-bit up/down modulo counter built from a bank of JK cells.
// Range is 0..MAX_COUNT with parallel load (clamped), enable, terminal-count
// flag and a registered wrap pulse. Defining JK_COUNTER_SATURATE_EN makes the
// counter stick at the boundaries instead of wrapping, and ties wrap low.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_COUNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

`ifdef JK_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_BOUNDARY_NEXT   = MAX_W;
  localparam logic [WIDTH-1:0] DOWN_BOUNDARY_NEXT = ZERO_W;
`else
  localparam logic [WIDTH-1:0] UP_BOUNDARY_NEXT   = ZERO_W;
  localparam logic [WIDTH-1:0] DOWN_BOUNDARY_NEXT = MAX_W;
`endif

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count_q == MAX_W);
  assign at_zero = (count_q == ZERO_W);

  // Terminal count: flags the cycle whose falling edge crosses a boundary
  assign tc = en & ~load & ~rst & ((up_dn & at_max) | (~up_dn & at_zero));

  // Next count value: load beats enable; boundaries handled explicitly so
  // WIDTH-bit arithmetic never overflows
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (up_dn) begin
        count_d = at_max ? UP_BOUNDARY_NEXT : (count_q + ONE_W);
      end else begin
        count_d = at_zero ? DOWN_BOUNDARY_NEXT : (count_q - ONE_W);
      end
    end
  end

  // Translate each bit's desired transition into JK drive
  always_comb begin
    jk_op_t op;
    op    = JK_HOLD;
    j_vec = '0;
    k_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op = jk_encode(count_q[i], count_d[i]);
      {j_vec[i], k_vec[i]} = op;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cells
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .J   (j_vec[g]),
      .K   (k_vec[g]),
      .Q   (count_q[g])
    );
  end

  assign count = count_q;

`ifdef JK_COUNTER_SATURATE_EN
  assign wrap = 1'b0;
`else
  logic wrap_q;
  logic wrap_d;

  // Wrap pulse source: the current terminal count, suppressed by a load
  always_comb begin
    wrap_d = tc & ~load;
  end

  // One-cycle wrap pulse registered on the falling edge
  always_ff @(negedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (default and MAX_COUNT=2
// instances). Expected values follow JK_COUNTER_SATURATE_EN when defined.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_val = 2'd0;
  logic [1:0] count;
  logic       tc;
  logic       wrap;
  logic [1:0] count2;
  logic       tc2;
  logic       wrap2;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef JK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
  int up_cnt [6] = '{1, 2, 3, 3, 3, 3};
  int up_tc  [6] = '{0, 0, 0, 1, 1, 1};
  int up_wr  [6] = '{0, 0, 0, 0, 0, 0};
  int dn_cnt [5] = '{0, 0, 0, 0, 0};
  int dn_tc  [5] = '{1, 1, 1, 1, 1};
  int dn_wr  [5] = '{0, 0, 0, 0, 0};
  int m2_cnt [4] = '{1, 2, 2, 2};
  int m2_tc  [4] = '{0, 0, 1, 1};
  int m2_wr  [4] = '{0, 0, 0, 0};
`else
  localparam bit SAT = 1'b0;
  int up_cnt [6] = '{1, 2, 3, 0, 1, 2};
  int up_tc  [6] = '{0, 0, 0, 1, 0, 0};
  int up_wr  [6] = '{0, 0, 0, 1, 0, 0};
  int dn_cnt [5] = '{3, 2, 1, 0, 3};
  int dn_tc  [5] = '{1, 0, 0, 0, 1};
  int dn_wr  [5] = '{1, 0, 0, 0, 1};
  int m2_cnt [4] = '{1, 2, 0, 1};
  int m2_tc  [4] = '{0, 0, 1, 0};
  int m2_wr  [4] = '{0, 0, 1, 0};
`endif

  jk_mod_counter #(.WIDTH(2), .MAX_COUNT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  jk_mod_counter #(.WIDTH(2), .MAX_COUNT(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count2),
    .tc       (tc2),
    .wrap     (wrap2)
  );

  // Free-running clock; the DUT acts on falling edges
  always #5 clk = ~clk;

  // Drive all inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic r, input logic e, input logic ud,
                               input logic ld, input logic [1:0] lv);
    rst      = r;
    en       = e;
    up_dn    = ud;
    load     = ld;
    load_val = lv;
    #1;
  endtask

  // Advance past one falling edge and sample well away from it
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_wrap", 32'(wrap), 0);
    checkOutput("rst_count2", 32'(count2), 0);

    // tc is masked while rst is high even with en=1, up_dn=0
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    checkOutput("rst_tc_mask", 32'(tc), 0);
    tick();
    checkOutput("rst2_count", 32'(count), 0);

    // Up counting
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("up_tc%0d", i), 32'(tc), 32'(up_tc[i]));
      tick();
      checkOutput($sformatf("up_cnt%0d", i), 32'(count), 32'(up_cnt[i]));
      checkOutput($sformatf("up_wrap%0d", i), 32'(wrap), 32'(up_wr[i]));
    end

    // Reset with en and load also high
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    checkOutput("rst_ld_tc", 32'(tc), 0);
    tick();
    checkOutput("rst_ld_count", 32'(count), 0);
    checkOutput("rst_ld_wrap", 32'(wrap), 0);

    // Down counting from zero
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("dn_tc%0d", i), 32'(tc), 32'(dn_tc[i]));
      tick();
      checkOutput($sformatf("dn_cnt%0d", i), 32'(count), 32'(dn_cnt[i]));
      checkOutput($sformatf("dn_wrap%0d", i), 32'(wrap), 32'(dn_wr[i]));
    end

    // Load beats enable, and clears wrap
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
    checkOutput("load_tc", 32'(tc), 0);
    tick();
    checkOutput("load2_count", 32'(count), 2);
    checkOutput("load2_wrap", 32'(wrap), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
    tick();
    checkOutput("load3_count", 32'(count), 3);

    // Boundary step up from MAX_COUNT
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    checkOutput("max_tc", 32'(tc), 1);
    tick();
    checkOutput("max_count", 32'(count), SAT ? 3 : 0);
    checkOutput("max_wrap", 32'(wrap), SAT ? 0 : 1);

    // A load right after a wrap drops the pulse
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
    tick();
    checkOutput("ldclr_count", 32'(count), 1);
    checkOutput("ldclr_wrap", 32'(wrap), 0);

    // Idle holds
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    checkOutput("idle_tc", 32'(tc), 0);
    tick();
    checkOutput("idle_count", 32'(count), 1);

    // Direction change takes effect on the very next edge
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    checkOutput("dir_up", 32'(count), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("dir_dn", 32'(count), 1);

    // Reset mid-count overrides load and enable
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    checkOutput("pre_rst_count", 32'(count), 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'd3);
    tick();
    checkOutput("mid_rst_count", 32'(count), 0);
    checkOutput("mid_rst_wrap", 32'(wrap), 0);

    // Reset pulsed between falling edges has no effect
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    tick();
    rst = 1'b1;
    #2;
    checkOutput("sync_rst_hi", 32'(count), 2);
    rst = 1'b0;
    #1;
    checkOutput("sync_rst_lo", 32'(count), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("sync_rst_edge", 32'(count), 2);

    // MAX_COUNT=2 instance: clamp on load, then up-count sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    checkOutput("m2_rst", 32'(count2), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    tick();
    checkOutput("m2_clamp", 32'(count2), 2);
    checkOutput("m3_noclamp", 32'(count), 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("m2_tc%0d", i), 32'(tc2), 32'(m2_tc[i]));
      tick();
      checkOutput($sformatf("m2_cnt%0d", i), 32'(count2), 32'(m2_cnt[i]));
      checkOutput($sformatf("m2_wrap%0d", i), 32'(wrap2), 32'(m2_wr[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised synchronous modulo counter built from a bank of JK storage cells. It generalises the single JK flip-flop into a WIDTH-bit up/down counter with a programmable terminal value, parallel load, enable and wrap reporting.
- It is the next-generation core for the count-to-N datapath. Its default parameters reproduce count-to-three: 0,1,2,3,0...
- Sits between the control FSM (en, up_dn, load) and display/consumer logic (count, tc, wrap).

Parameters:
- WIDTH, 2, counter width in bits; must satisfy WIDTH >= $clog2(MAX_COUNT+1).
- MAX_COUNT, 3, terminal value; counter range is 0..MAX_COUNT; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous reset, active-high, sampled on the falling edge of clk.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count.
- tc  output  1  terminal-count flag (combinational).
- wrap  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- All state changes on negedge clk; reset is synchronous (no async path). Priority: rst > load > en.
- Reset: count=0, wrap=0. tc then follows its equation, e.g. tc=1 if en=1 and up_dn=0.
- Load: count <= min(load_val, MAX_COUNT); wrap <= 0. Out-of-range loads clamp to MAX_COUNT.
- Enabled counting (en=1, load=0):
  - Up: count==MAX_COUNT -> 0, otherwise count+1.
  - Down: count==0 -> MAX_COUNT, otherwise count-1.
  - Latency: count reflects the step on the falling edge where en is sampled high.
- Idle: en=0 and load=0 -> count holds (JK 00 on every bit).
- tc = en & ~load & ~rst & ((up_dn & count==MAX_COUNT) | (~up_dn & count==0)). Combinational; asserted during the cycle whose edge will wrap.
- wrap <= tc at each falling edge (i.e. high for exactly one cycle after a wrap); cleared by rst and by load.
- Bit update: next value computed per bit, then mapped to JK as J_i = next_i & ~q_i and K_i = ~next_i & q_i. The result is a hold/set/reset per bit; toggles never apply to a stable bit.
- Direction change mid-sequence takes effect on the next enabled edge; no extra latency.
- Reset asserted mid-count: count=0 on that edge, regardless of en/load.
- Arithmetic is in WIDTH bits. Comparisons use MAX_COUNT cast to WIDTH; no intermediate overflow is possible because wrap is explicit.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined: counting up at MAX_COUNT holds MAX_COUNT, and counting down at 0 holds 0. tc behaves as specified (flags the boundary). wrap never asserts; it is tied 0.
- Undefined: modulo wrap-around as above.

Decomposition:
- Package jk_counter_pkg:
  - enum jk_op_t {JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11}.
  - Function jk_encode(cur, nxt) returning jk_op_t.
- Sub-module jk_cell: one JK bit with synchronous active-high rst, negedge clk, ports clk/rst/J/K/Q. jk_mod_counter instantiates WIDTH of them in a generate loop.

Test Plan (defaults WIDTH=2, MAX_COUNT=3):
- Reset then en=1, up_dn=1 for 5 edges -> count 1,2,3,0,1. tc high while count==3. wrap high exactly one cycle, the cycle after the 3->0 edge.
- en=1, up_dn=0 from count=0 -> count 3,2,1,0,3. tc high whenever count==0. wrap after each 0->3 edge.
- load=1, load_val=2, en=1 same cycle -> count=2, not 3 (load beats en). Then load_val=3 -> count=3.
- Build with MAX_COUNT=2, WIDTH=2, load_val=3 -> count clamps to 2. Up-count sequence 0,1,2,0.
- rst=1 with en=1, load=1, count=2 -> count=0, wrap=0 on that edge. rst toggled between falling edges does not change count until the next falling edge (proves synchronous reset).
- With JK_COUNTER_SATURATE_EN defined, up-count from 0 for 6 edges -> 1,2,3,3,3,3. wrap stays 0. tc=1 while count==3 and en=1.
